// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
// Configures one PWM modulator and soft-starts it: writes the period divider,
// then the enable, then walks the setpoint toward a target by one step per PWM
// period. Write strobes are held for half of a WR_CYCLES-long sequence so the
// modulator's 2-flop edge detectors see a clean, long pulse with stable data.

module pwm_ramp_ctrl #(
    parameter int MOD_WIDTH = 8,
    parameter int WR_CYCLES = 4,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 cfg_en,
    input  logic [7:0]           cfg_div,
    input  logic [MOD_WIDTH-1:0] cfg_target,
    input  logic [MOD_WIDTH-1:0] cfg_step,
    input  logic                 abort,
    input  logic                 start_strobe,
    output logic                 pwm_en,
    output logic                 wr_en,
    output logic                 wr_pwm_period_div,
    output logic                 wr_mod_setpoint,
    output logic [7:0]           pwm_period_div,
    output logic [MOD_WIDTH-1:0] mod_setpoint,
    output logic                 ramping,
    output logic                 done,
    output logic                 timeout_err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int CNT_W = (WR_CYCLES > 2) ? $clog2(WR_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(WR_CYCLES / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WR_DIV    = 3'd1;
    localparam logic [2:0] ST_WR_EN     = 3'd2;
    localparam logic [2:0] ST_RAMP_WAIT = 3'd3;
    localparam logic [2:0] ST_WR_SP     = 3'd4;
    localparam logic [2:0] ST_WR_OFF    = 3'd5;

    // ------------------------------------------------------------------
    // Next setpoint: one step toward the target, clamped at the target so
    // it never overshoots and never wraps. A zero step jumps straight there.
    // ------------------------------------------------------------------
    function automatic logic [MOD_WIDTH-1:0] next_setpoint(
        input logic [MOD_WIDTH-1:0] cur,
        input logic [MOD_WIDTH-1:0] tgt,
        input logic [MOD_WIDTH-1:0] step
    );
        logic [MOD_WIDTH-1:0] diff;
        logic [MOD_WIDTH-1:0] res;
        if ((step == '0) || (cur == tgt)) begin
            diff = '0;
            res  = tgt;
        end else if (tgt > cur) begin
            diff = tgt - cur;
            res  = (diff <= step) ? tgt : (cur + step);
        end else begin
            diff = cur - tgt;
            res  = (diff <= step) ? tgt : (cur - step);
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]           state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [15:0]          tmo_cnt_r;
    logic                 en_r;
    logic [MOD_WIDTH-1:0] target_r;
    logic [MOD_WIDTH-1:0] step_r;
    logic                 abort_pend_r;
    logic                 sync1_r;
    logic                 sync2_r;
    logic                 sync3_r;
    logic                 edge_r;

    logic                 pwm_en_r;
    logic                 wr_en_r;
    logic                 wr_div_r;
    logic                 wr_sp_r;
    logic [7:0]           div_out_r;
    logic [MOD_WIDTH-1:0] sp_r;
    logic                 ramping_r;
    logic                 timeout_err_r;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [2:0]           state_nxt_s;
    logic [CNT_W-1:0]     cnt_nxt_s;
    logic                 done_s;
    logic                 tmo_hit_s;
    logic                 ready_s;
    logic                 accept_s;
    logic                 seq_last_s;
    logic                 in_seq_s;
    logic                 abort_seen_s;
    logic [MOD_WIDTH-1:0] sp_next_s;

    assign ready_s      = (state_r == ST_IDLE) && !rst;
    assign accept_s     = cfg_valid && ready_s;
    assign seq_last_s   = (cnt_r == CNT_LAST);
    // Sequences that may be interrupted by abort once they finish.
    assign in_seq_s     = (state_r == ST_WR_DIV) || (state_r == ST_WR_EN) ||
                          (state_r == ST_WR_SP);
    assign abort_seen_s = abort_pend_r || abort;
    assign sp_next_s    = next_setpoint(sp_r, target_r, step_r);

    // Next-state, sequence counter, completion and timeout decisions.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = CNT_ZERO;
        done_s      = 1'b0;
        tmo_hit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_WR_DIV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_DIV: begin
                if (seq_last_s) begin
                    state_nxt_s = abort_seen_s ? ST_WR_OFF : ST_WR_EN;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_WR_EN: begin
                if (!seq_last_s) begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end else if (abort_seen_s) begin
                    state_nxt_s = ST_WR_OFF;
                end else if (!en_r || (sp_r == target_r)) begin
                    state_nxt_s = ST_IDLE;
                    done_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_RAMP_WAIT;
                end
            end
            ST_RAMP_WAIT: begin
                // abort beats a period edge, a period edge beats timeout
                if (abort) begin
                    state_nxt_s = ST_WR_OFF;
                end else if (edge_r) begin
                    state_nxt_s = ST_WR_SP;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_nxt_s = ST_WR_OFF;
                    tmo_hit_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_RAMP_WAIT;
                end
            end
            ST_WR_SP: begin
                if (!seq_last_s) begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end else if (abort_seen_s) begin
                    state_nxt_s = ST_WR_OFF;
                end else if (sp_r == target_r) begin
                    state_nxt_s = ST_IDLE;
                    done_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_RAMP_WAIT;
                end
            end
            ST_WR_OFF: begin
                if (seq_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control state: FSM, counters, command latch, abort memory, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            tmo_cnt_r     <= 16'd0;
            en_r          <= 1'b0;
            target_r      <= '0;
            step_r        <= '0;
            abort_pend_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            // counts only while waiting, so it is zero on every entry
            tmo_cnt_r <= (state_r == ST_RAMP_WAIT) ? (tmo_cnt_r + 16'd1) : 16'd0;
            if (accept_s) begin
                en_r     <= cfg_en;
                target_r <= cfg_target;
                step_r   <= cfg_step;
            end else begin
                en_r     <= en_r;
                target_r <= target_r;
                step_r   <= step_r;
            end
            // remembered until the running sequence ends, then consumed
            abort_pend_r <= (in_seq_s && !seq_last_s) ? abort_seen_s : 1'b0;
            if (accept_s) begin
                timeout_err_r <= 1'b0;
            end else if (tmo_hit_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    // start_strobe synchronizer and registered rising-edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
            edge_r  <= 1'b0;
        end else begin
            sync1_r <= start_strobe;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            edge_r  <= sync2_r && !sync3_r;
        end
    end

    // Modulator-facing outputs, registered from the next state so data and
    // strobe change together on the first cycle of each write sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_en_r  <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_div_r  <= 1'b0;
            wr_sp_r   <= 1'b0;
            div_out_r <= 8'd0;
            sp_r      <= '0;
            ramping_r <= 1'b0;
        end else begin
            wr_div_r  <= (state_nxt_s == ST_WR_DIV) && (cnt_nxt_s < CNT_HALF);
            wr_en_r   <= ((state_nxt_s == ST_WR_EN) || (state_nxt_s == ST_WR_OFF)) &&
                         (cnt_nxt_s < CNT_HALF);
            wr_sp_r   <= (state_nxt_s == ST_WR_SP) && (cnt_nxt_s < CNT_HALF);
            ramping_r <= (state_nxt_s == ST_RAMP_WAIT) || (state_nxt_s == ST_WR_SP);

            if (accept_s) begin
                div_out_r <= cfg_div;
            end else begin
                div_out_r <= div_out_r;
            end

            if ((state_nxt_s == ST_WR_EN) && (state_r != ST_WR_EN)) begin
                pwm_en_r <= en_r;
            end else if ((state_nxt_s == ST_WR_OFF) && (state_r != ST_WR_OFF)) begin
                pwm_en_r <= 1'b0;
            end else begin
                pwm_en_r <= pwm_en_r;
            end

            if ((state_nxt_s == ST_WR_SP) && (state_r == ST_RAMP_WAIT)) begin
                sp_r <= sp_next_s;
            end else begin
                sp_r <= sp_r;
            end
        end
    end

    // done marks the last cycle of the completing sequence, so the host sees
    // cfg_ready rise in the very next cycle.
    assign done              = done_s && !rst;
    assign cfg_ready         = ready_s;
    assign pwm_en            = pwm_en_r;
    assign wr_en             = wr_en_r;
    assign wr_pwm_period_div = wr_div_r;
    assign wr_mod_setpoint   = wr_sp_r;
    assign pwm_period_div    = div_out_r;
    assign mod_setpoint      = sp_r;
    assign ramping           = ramping_r;
    assign timeout_err       = timeout_err_r;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: the stimulus pushes the expected write
// and done events, a negedge monitor pops and compares them as they appear.

module tb_pwm_ramp_ctrl;

    localparam int MW = 8;
    localparam int WC = 4;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          cfg_en = 1'b0;
    logic [7:0]    cfg_div = 8'd0;
    logic [MW-1:0] cfg_target = '0;
    logic [MW-1:0] cfg_step = '0;
    logic          abort = 1'b0;
    logic          start_strobe = 1'b0;
    logic          pwm_en;
    logic          wr_en;
    logic          wr_pwm_period_div;
    logic          wr_mod_setpoint;
    logic [7:0]    pwm_period_div;
    logic [MW-1:0] mod_setpoint;
    logic          ramping;
    logic          done;
    logic          timeout_err;

    pwm_ramp_ctrl #(.MOD_WIDTH(MW), .WR_CYCLES(WC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_en(cfg_en), .cfg_div(cfg_div), .cfg_target(cfg_target),
        .cfg_step(cfg_step), .abort(abort), .start_strobe(start_strobe),
        .pwm_en(pwm_en), .wr_en(wr_en), .wr_pwm_period_div(wr_pwm_period_div),
        .wr_mod_setpoint(wr_mod_setpoint), .pwm_period_div(pwm_period_div),
        .mod_setpoint(mod_setpoint), .ramping(ramping), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // event kinds
    localparam int K_DIV  = 0;
    localparam int K_EN   = 1;
    localparam int K_SP   = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int kind;
        int data;
        int terr;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input int data, input int terr);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.terr = terr;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int kind, input int data);
        ev_t e;
        int  a;
        a = kind * 4096 + data * 2 + int'(timeout_err);
        if (exp_q.size() == 0) begin
            check("unexpected_event", a, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("event", a, e.kind * 4096 + e.data * 2 + e.terr);
        end
    endtask

    // Monitor: strobe rising edges and done pulses become events; each strobe
    // must stay high exactly WC/2 cycles.
    int  len_div = 0, len_en = 0, len_sp = 0;
    logic p_div = 1'b0, p_en = 1'b0, p_sp = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            len_div = 0; len_en = 0; len_sp = 0;
            p_div = 1'b0; p_en = 1'b0; p_sp = 1'b0;
        end else begin
            if (wr_pwm_period_div && !p_div) got_ev(K_DIV, int'(pwm_period_div));
            if (wr_en && !p_en)              got_ev(K_EN, int'(pwm_en));
            if (wr_mod_setpoint && !p_sp)    got_ev(K_SP, int'(mod_setpoint));
            if (done)                        got_ev(K_DONE, 0);
            if (wr_pwm_period_div) len_div++;
            else if (p_div) begin check("div_strobe_len", len_div, WC / 2); len_div = 0; end
            if (wr_en) len_en++;
            else if (p_en) begin check("en_strobe_len", len_en, WC / 2); len_en = 0; end
            if (wr_mod_setpoint) len_sp++;
            else if (p_sp) begin check("sp_strobe_len", len_sp, WC / 2); len_sp = 0; end
            p_div = wr_pwm_period_div;
            p_en  = wr_en;
            p_sp  = wr_mod_setpoint;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!cfg_ready && n < 400) begin @(negedge clk); n++; end
        if (!cfg_ready) check("wait_ready_timeout", 0, 1);
    endtask

    task automatic wait_ramping();
        int n = 0;
        while (!ramping && n < 50) begin @(negedge clk); n++; end
        if (!ramping) check("wait_ramping_timeout", 0, 1);
    endtask

    task automatic send_cmd(input logic en, input logic [7:0] div,
                            input logic [MW-1:0] tgt, input logic [MW-1:0] step);
        wait_ready();
        cfg_valid  = 1'b1;
        cfg_en     = en;
        cfg_div    = div;
        cfg_target = tgt;
        cfg_step   = step;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("div_strobe_start", wr_pwm_period_div, 1);
    endtask

    // Raise start_strobe for two cycles and wait for the setpoint write; it
    // must start four edges after the first edge that samples the strobe.
    task automatic strobe_and_wait();
        int n = 0;
        start_strobe = 1'b1;
        while (!wr_mod_setpoint && n < 20) begin
            @(negedge clk);
            n++;
            if (n >= 2) start_strobe = 1'b0;
        end
        start_strobe = 1'b0;
        check("strobe_latency", n, 4);
    endtask

    task automatic ramp_step();
        wait_ramping();
        strobe_and_wait();
        repeat (WC) @(negedge clk);
    endtask

    initial begin
        int n;
        // reset state
        repeat (3) @(negedge clk);
        check("ready_in_reset", cfg_ready, 0);
        check("reset_outputs", {pwm_en, wr_en, wr_pwm_period_div, wr_mod_setpoint,
              pwm_period_div, mod_setpoint, ramping, done, timeout_err}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", cfg_ready, 1);

        // ramp up 0 -> 0x40 in steps of 0x10
        expect_ev(K_DIV, 12, 0); expect_ev(K_EN, 1, 0);
        expect_ev(K_SP, 8'h10, 0); expect_ev(K_SP, 8'h20, 0);
        expect_ev(K_SP, 8'h30, 0); expect_ev(K_SP, 8'h40, 0);
        expect_ev(K_DONE, 0, 0);
        send_cmd(1'b1, 8'd12, 8'h40, 8'h10);
        for (int i = 0; i < 4; i++) ramp_step();
        wait_ready();
        check("sp_after_up", mod_setpoint, 8'h40);

        // ramp down 0x40 -> 0x05, last step clamped
        expect_ev(K_DIV, 12, 0); expect_ev(K_EN, 1, 0);
        expect_ev(K_SP, 8'h30, 0); expect_ev(K_SP, 8'h20, 0);
        expect_ev(K_SP, 8'h10, 0); expect_ev(K_SP, 8'h05, 0);
        expect_ev(K_DONE, 0, 0);
        send_cmd(1'b1, 8'd12, 8'h05, 8'h10);
        for (int i = 0; i < 4; i++) ramp_step();
        wait_ready();
        check("sp_after_down", mod_setpoint, 8'h05);

        // step 0 jumps to target
        expect_ev(K_DIV, 12, 0); expect_ev(K_EN, 1, 0);
        expect_ev(K_SP, 8'hFF, 0); expect_ev(K_DONE, 0, 0);
        send_cmd(1'b1, 8'd12, 8'hFF, 8'h00);
        ramp_step();
        wait_ready();

        // enable 0 finishes right after the enable write
        expect_ev(K_DIV, 7, 0); expect_ev(K_EN, 0, 0); expect_ev(K_DONE, 0, 0);
        send_cmd(1'b0, 8'd7, 8'h10, 8'h01);
        wait_ready();
        check("pwm_en_off", pwm_en, 0);

        // abort in IDLE is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle_ready", cfg_ready, 1);

        // timeout: no period edges for TO cycles, then WR_OFF
        expect_ev(K_DIV, 12, 0); expect_ev(K_EN, 1, 0); expect_ev(K_EN, 0, 1);
        send_cmd(1'b1, 8'd12, 8'h00, 8'h40);
        wait_ramping();
        n = 0;
        while (ramping && n < 300) begin @(negedge clk); n++; end
        check("ramp_wait_cycles", n, TO);
        wait_ready();
        check("timeout_sticky", timeout_err, 1);
        check("sp_after_timeout", mod_setpoint, 8'hFF);

        // abort during setpoint write: write completes, WR_OFF, no done
        expect_ev(K_DIV, 5, 0); expect_ev(K_EN, 1, 0);
        expect_ev(K_SP, 8'hBF, 0); expect_ev(K_EN, 0, 0);
        send_cmd(1'b1, 8'd5, 8'h00, 8'h40);
        check("timeout_cleared", timeout_err, 0);
        wait_ramping();
        strobe_and_wait();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_ready();
        check("pwm_en_after_abort", pwm_en, 0);
        check("sp_after_abort", mod_setpoint, 8'hBF);

        // reset during the setpoint strobe
        expect_ev(K_DIV, 12, 0); expect_ev(K_EN, 1, 0); expect_ev(K_SP, 8'h7F, 0);
        send_cmd(1'b1, 8'd12, 8'h00, 8'h40);
        wait_ramping();
        strobe_and_wait();
        #1 rst = 1'b1;
        @(negedge clk);
        check("outputs_after_rst", {pwm_en, wr_en, wr_pwm_period_div, wr_mod_setpoint,
              pwm_period_div, mod_setpoint, ramping, done, timeout_err}, 0);
        check("ready_during_rst", cfg_ready, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", cfg_ready, 1);

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
